// File: rtl/fg_cfg_dac_ctrl.sv
// Function-generator glue: host config register bank behind a synchronised write
// strobe, plus a DAC write-strobe/settle controller. Optional: FG_SHADOW_COMMIT_EN.
module fg_cfg_dac_ctrl #(
  parameter int DATA_W        = 8,
  parameter int NUM_REGS      = 8,
  parameter int ADDR_W        = 3,
  parameter int DAC_W         = 8,
  parameter int SYNC_STAGES   = 2,
  parameter int WR_PULSE      = 2,
  parameter int SETTLE_CYCLES = 499
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic [DATA_W-1:0]          data_i,
  input  logic [ADDR_W-1:0]          addr_i,
  input  logic                       wr_async_i,
  output logic [NUM_REGS*DATA_W-1:0] cr_bus_o,
  output logic                       cr_update_o,
  input  logic [DAC_W-1:0]           sample_i,
  input  logic                       sample_valid_i,
  output logic                       busy_o,
  output logic                       overrun_o,
  input  logic                       overrun_clr_i,
  output logic [DAC_W-1:0]           dac_data_o,
  output logic                       dac_wr_n_o,
  output logic                       dac_clr_n_o,
  output logic                       dac_pd_n_o
);

  localparam int MAX_CNT = (WR_PULSE > SETTLE_CYCLES) ? WR_PULSE : SETTLE_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);
  localparam logic [CNT_W-1:0] PULSE_LD  = CNT_W'(WR_PULSE - 1);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

  // ---------------------------------------------------------------- write path
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   wr_prev_q;
  logic                   wr_pulse;
  logic [NUM_REGS-1:0]    addr_sel;
  logic [DATA_W-1:0]      cr_q [NUM_REGS];
  logic                   cr_update_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync_q    <= '0;
      wr_prev_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], wr_async_i};
      wr_prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign wr_pulse = sync_q[SYNC_STAGES-1] & ~wr_prev_q;

  // Out-of-range addresses select nothing, so they neither write nor pulse.
  always_comb begin
    addr_sel = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      addr_sel[i] = (addr_i == ADDR_W'(i));
    end
  end

`ifdef FG_SHADOW_COMMIT_EN
  logic [DATA_W-1:0] sh_q [NUM_REGS];
  logic              commit;

  assign commit = wr_pulse & addr_sel[NUM_REGS-1];

  // The committing write bypasses its own shadow so the bus sees it in the same edge.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        sh_q[i] <= '0;
        cr_q[i] <= '0;
      end
      cr_update_q <= 1'b0;
    end else begin
      cr_update_q <= commit;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (wr_pulse && addr_sel[i]) sh_q[i] <= data_i;
        if (commit) cr_q[i] <= (i == NUM_REGS - 1) ? data_i : sh_q[i];
      end
    end
  end
`else
  logic wr_en;

  assign wr_en = wr_pulse & (|addr_sel);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        cr_q[i] <= '0;
      end
      cr_update_q <= 1'b0;
    end else begin
      cr_update_q <= wr_en;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (wr_pulse && addr_sel[i]) cr_q[i] <= data_i;
      end
    end
  end
`endif

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_bus
    assign cr_bus_o[(NUM_REGS-1-g)*DATA_W +: DATA_W] = cr_q[g];
  end

  assign cr_update_o = cr_update_q;

  // ------------------------------------------------------------------ DAC FSM
  typedef enum logic [1:0] {IDLE, STROBE, SETTLE} dac_state_e;

  dac_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DAC_W-1:0] data_q, data_d;
  logic             wr_n_q, wr_n_d;
  logic             ovr_q, ovr_d;
  logic             busy_q;
  logic             en_q;
  logic             accept, drop;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      wr_n_q  <= 1'b1;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      wr_n_q  <= wr_n_d;
      ovr_q   <= ovr_d;
      busy_q  <= (state_d != IDLE);
      en_q    <= 1'b1;
    end
  end

  // With no settle time the last strobe cycle also accepts the next sample,
  // so samples spaced WR_PULSE apart keep the strobe low and update the data.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    wr_n_d  = wr_n_q;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: accept = sample_valid_i;
      STROBE: begin
        if (cnt_q == '0) begin
          wr_n_d = 1'b1;
          if (SETTLE_CYCLES > 0) begin
            state_d = SETTLE;
            cnt_d   = SETTLE_LD;
          end else begin
            state_d = IDLE;
            accept  = sample_valid_i;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      SETTLE: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      state_d = STROBE;
      cnt_d   = PULSE_LD;
      data_d  = sample_i;
      wr_n_d  = 1'b0;
    end
    drop = sample_valid_i & ~accept & (state_q != IDLE);
    if (drop)               ovr_d = 1'b1;
    else if (overrun_clr_i) ovr_d = 1'b0;
    else                    ovr_d = ovr_q;
  end

  assign busy_o      = busy_q;
  assign overrun_o   = ovr_q;
  assign dac_data_o  = data_q;
  assign dac_wr_n_o  = wr_n_q;
  assign dac_clr_n_o = en_q;
  assign dac_pd_n_o  = en_q;

endmodule
